// File: rtl/fetch_prefetch_pkg.sv
// Shared RISC-V constants and the queue-operation encoding used by the fetch prefetch block.
package fetch_prefetch_pkg;

  localparam int          ILEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [2:0] {
    Q_IDLE     = 3'd0,
    Q_PUSH     = 3'd1,
    Q_POP      = 3'd2,
    Q_PUSH_POP = 3'd3,
    Q_FLUSH    = 3'd4,
    Q_RESET    = 3'd5
  } q_op_e;

  // Classifies the queue activity of one cycle; reset outranks flush, flush outranks push/pop.
  function automatic q_op_e q_op(input logic rst, input logic flush,
                                 input logic push, input logic pop);
    if (rst)             return Q_RESET;
    if (flush)           return Q_FLUSH;
    if (push && pop)     return Q_PUSH_POP;
    if (push)            return Q_PUSH;
    if (pop)             return Q_POP;
    return Q_IDLE;
  endfunction

endpackage

// File: rtl/fetch_prefetch_if.sv
// Fetch-stage bus: redirect/stall from the pipeline, instruction memory port, head-entry outputs.
interface fetch_prefetch_if #(
  parameter int XLEN = 64
);
  import fetch_prefetch_pkg::*;

  // Handshake: the head entry transfers on a rising edge when ValidF=1 and StallF=0 and
  // PCSrcE=0; ValidF never depends on StallF, and a redirect discards whatever is offered.
  logic            PCSrcE;
  logic [XLEN-1:0] pc_target;
  logic            StallF;
  logic [XLEN-1:0] imem_addr;
  logic [ILEN-1:0] imem_rdata;
  logic [ILEN-1:0] InstrF;
  logic [XLEN-1:0] PCF;
  logic [XLEN-1:0] PCPlus4F;
  logic            ValidF;

  modport master (
    output PCSrcE, pc_target, StallF, imem_rdata,
    input  imem_addr, InstrF, PCF, PCPlus4F, ValidF
  );

  modport slave (
    input  PCSrcE, pc_target, StallF, imem_rdata,
    output imem_addr, InstrF, PCF, PCPlus4F, ValidF
  );

endinterface

// File: rtl/fetch_prefetch_queue.sv
// Power-of-two FIFO of fetched {pc, instr} pairs; head is read from registered storage.
module fetch_queue #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rptr;
  logic [AW-1:0]    wptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  // A push into a full queue is only legal when the head leaves in the same cycle.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rptr    <= '0;
      wptr    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !reset && !flush) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction prefetcher: fetch PC register, push/pop/redirect control and head-entry output mux.
module fetch_prefetch
  import fetch_prefetch_pkg::*;
#(
  parameter int              XLEN         = 64,
  parameter int              DEPTH        = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  localparam int             CW           = $clog2(DEPTH + 1)
) (
  input  logic                   clock,
  input  logic                   reset_pc,
  fetch_prefetch_if.slave        bus,
  output logic [CW-1:0]          dbg_count,
  output q_op_e                  dbg_op
);

  localparam int QW = XLEN + ILEN;

  logic [XLEN-1:0] fpc;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic [QW-1:0]   wdata;
  logic [QW-1:0]   rdata;

  // Redirect wins over both directions; a pop frees the slot the same-cycle push lands in.
  always_comb begin
    pop   = !empty && !bus.StallF && !bus.PCSrcE;
    push  = !bus.PCSrcE && (!full || pop);
    wdata = {fpc, bus.imem_rdata};
  end

  always_ff @(posedge clock) begin
    if (reset_pc) begin
      fpc <= RESET_VECTOR;
    end else if (bus.PCSrcE) begin
      fpc <= bus.pc_target & ~XLEN'(3);
    end else if (push) begin
      fpc <= fpc + XLEN'(4);
    end
  end

  fetch_queue #(
    .WIDTH (QW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clock (clock),
    .reset (reset_pc),
    .push  (push),
    .pop   (pop),
    .flush (bus.PCSrcE),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (dbg_count)
  );

  assign bus.imem_addr = fpc;

  always_comb begin
    bus.ValidF   = !empty;
    bus.PCF      = '0;
    bus.InstrF   = NOP_INSTR;
    if (!empty) begin
      bus.PCF    = rdata[QW-1:ILEN];
      bus.InstrF = rdata[ILEN-1:0];
    end
    bus.PCPlus4F = bus.PCF + XLEN'(4);
  end

  assign dbg_op = q_op(reset_pc, bus.PCSrcE, push, pop);

endmodule
